// File: rtl/ifft16_seq.sv
// ifft16_seq: sequential 16-point radix-2 inverse FFT with 1/16 scaling.
// Bins arrive serially in natural order and are stored at bit-reversed
// addresses. They are processed in place by one decimation-in-time butterfly
// per cycle (4 stages x 8 butterflies). Time samples are streamed out in
// natural order, saturated to OW bits.
module ifft16_seq #(
    parameter int IW = 20,
    parameter int OW = 16,
    parameter int TW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*IW-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OW-1:0]   out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int MW = IW + 1;        // storage word: one guard bit per component
    localparam int PW = MW + TW + 1;   // width of b*W component sums
    localparam int SW = PW - 14;       // width after removing the Q1.14 fraction

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // Bit reversal of a 4-bit bin index.
    function automatic logic [3:0] rev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // cos(2*pi*m/16) in Q1.14.
    function automatic logic signed [TW-1:0] tw_cos(input logic [2:0] m);
        case (m)
            3'd0:    return 16'sd16384;
            3'd1:    return 16'sd15137;
            3'd2:    return 16'sd11585;
            3'd3:    return 16'sd6270;
            3'd4:    return 16'sd0;
            3'd5:    return -16'sd6270;
            3'd6:    return -16'sd11585;
            3'd7:    return -16'sd15137;
            default: return 16'sd0;
        endcase
    endfunction

    // sin(2*pi*m/16) in Q1.14; the positive sign gives the inverse transform.
    function automatic logic signed [TW-1:0] tw_sin(input logic [2:0] m);
        case (m)
            3'd0:    return 16'sd0;
            3'd1:    return 16'sd6270;
            3'd2:    return 16'sd11585;
            3'd3:    return 16'sd15137;
            3'd4:    return 16'sd16384;
            3'd5:    return 16'sd15137;
            3'd6:    return 16'sd11585;
            3'd7:    return 16'sd6270;
            default: return 16'sd0;
        endcase
    endfunction

    // Clamp a stored component to the signed OW-bit output range.
    function automatic logic [OW-1:0] sat(input logic signed [MW-1:0] v);
        if (v[MW-1:OW-1] == {(MW-OW+1){v[MW-1]}}) begin
            return v[OW-1:0];
        end else if (v[MW-1]) begin
            return {1'b1, {(OW-1){1'b0}}};
        end else begin
            return {1'b0, {(OW-1){1'b1}}};
        end
    endfunction

    state_t                r_state;
    state_t                w_next_state;
    logic signed [MW-1:0]  r_mem_re [16];
    logic signed [MW-1:0]  r_mem_im [16];
    logic [3:0]            r_cnt;
    logic [1:0]            r_stage;
    logic [2:0]            r_bfly;
    logic [3:0]            r_idx;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [2*OW-1:0]       r_out_data;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_cnt_last;
    logic                  w_err;
    logic                  w_comp_done;
    logic [3:0]            w_wr_addr;
    logic [3:0]            w_bf_i;
    logic [3:0]            w_bf_h;
    logic [3:0]            w_bf_ih;
    logic [2:0]            w_tw_m;
    logic signed [TW-1:0]  w_cos;
    logic signed [TW-1:0]  w_sin;
    logic signed [MW-1:0]  w_a_re;
    logic signed [MW-1:0]  w_a_im;
    logic signed [MW-1:0]  w_b_re;
    logic signed [MW-1:0]  w_b_im;
    logic signed [PW-1:0]  w_p_re;
    logic signed [PW-1:0]  w_p_im;
    logic signed [SW-1:0]  w_t_re;
    logic signed [SW-1:0]  w_t_im;
    logic signed [SW-1:0]  w_sum_re;
    logic signed [SW-1:0]  w_sum_im;
    logic signed [SW-1:0]  w_dif_re;
    logic signed [SW-1:0]  w_dif_im;
    logic [3:0]            w_rd_idx;
    logic [2*OW-1:0]       w_sample;

    assign w_accept    = in_valid && r_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_cnt_last  = (r_cnt == 4'd15);
    // Early in_last, or a missing in_last on bin 15, are both framing errors.
    assign w_err       = w_accept && (in_last != w_cnt_last);
    assign w_comp_done = (r_stage == 2'd3) && (r_bfly == 3'd7);
    assign w_wr_addr   = rev4(r_cnt);

    // Butterfly addressing: index i, span h and twiddle exponent m for this cycle.
    always_comb begin
        w_bf_i = 4'd0;
        w_bf_h = 4'd1;
        w_tw_m = 3'd0;
        case (r_stage)
            2'd0: begin w_bf_i = {r_bfly, 1'b0};                  w_bf_h = 4'd1; w_tw_m = 3'd0;                 end
            2'd1: begin w_bf_i = {r_bfly[2:1], 1'b0, r_bfly[0]};  w_bf_h = 4'd2; w_tw_m = {r_bfly[0], 2'b00};   end
            2'd2: begin w_bf_i = {r_bfly[2], 1'b0, r_bfly[1:0]};  w_bf_h = 4'd4; w_tw_m = {r_bfly[1:0], 1'b0};  end
            2'd3: begin w_bf_i = {1'b0, r_bfly};                  w_bf_h = 4'd8; w_tw_m = r_bfly;               end
            default: begin w_bf_i = 4'd0; w_bf_h = 4'd1; w_tw_m = 3'd0; end
        endcase
    end

    assign w_bf_ih  = w_bf_i + w_bf_h;
    assign w_cos    = tw_cos(w_tw_m);
    assign w_sin    = tw_sin(w_tw_m);
    assign w_a_re   = r_mem_re[w_bf_i];
    assign w_a_im   = r_mem_im[w_bf_i];
    assign w_b_re   = r_mem_re[w_bf_ih];
    assign w_b_im   = r_mem_im[w_bf_ih];
    // b*W with round-half-up into the Q1.14 shift.
    assign w_p_re   = PW'(w_b_re) * PW'(w_cos) - PW'(w_b_im) * PW'(w_sin) + PW'(15'sd8192);
    assign w_p_im   = PW'(w_b_re) * PW'(w_sin) + PW'(w_b_im) * PW'(w_cos) + PW'(15'sd8192);
    assign w_t_re   = SW'(w_p_re >>> 14);
    assign w_t_im   = SW'(w_p_im >>> 14);
    assign w_sum_re = SW'(w_a_re) + w_t_re;
    assign w_sum_im = SW'(w_a_im) + w_t_im;
    assign w_dif_re = SW'(w_a_re) - w_t_re;
    assign w_dif_im = SW'(w_a_im) - w_t_im;

    // While a sample is on the bus, prefetch the next one so accepts are back-to-back.
    assign w_rd_idx = r_out_valid ? (r_idx + 4'd1) : r_idx;
    assign w_sample = {sat(r_mem_im[w_rd_idx]), sat(r_mem_re[w_rd_idx])};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: LOAD -> COMPUTE -> UNLOAD -> LOAD.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && w_cnt_last) begin
                    w_next_state = ST_COMPUTE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (w_comp_done) begin
                    w_next_state = ST_UNLOAD;
                end else begin
                    w_next_state = ST_COMPUTE;
                end
            end
            ST_UNLOAD: begin
                if (w_out_fire && (r_idx == 4'd15)) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_UNLOAD;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Working memory: bit-reversed bin writes in LOAD, in-place butterflies in COMPUTE.
    always_ff @(posedge clk) begin
        if ((r_state == ST_LOAD) && w_accept) begin
            r_mem_re[w_wr_addr] <= {in_data[IW-1], in_data[IW-1:0]};
            r_mem_im[w_wr_addr] <= {in_data[2*IW-1], in_data[2*IW-1:IW]};
        end else if (r_state == ST_COMPUTE) begin
            r_mem_re[w_bf_i]  <= MW'(w_sum_re >>> 1);
            r_mem_im[w_bf_i]  <= MW'(w_sum_im >>> 1);
            r_mem_re[w_bf_ih] <= MW'(w_dif_re >>> 1);
            r_mem_im[w_bf_ih] <= MW'(w_dif_im >>> 1);
        end
    end

    // Counters and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_stage     <= 2'd0;
            r_bfly      <= 3'd0;
            r_idx       <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= {(2*OW){1'b0}};
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == ST_LOAD);
            r_busy     <= (w_next_state != ST_LOAD);
            r_err      <= w_err;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= (in_last || w_cnt_last) ? 4'd0 : (r_cnt + 4'd1);
                    end
                end
                ST_COMPUTE: begin
                    {r_stage, r_bfly} <= {r_stage, r_bfly} + 5'd1;
                end
                ST_UNLOAD: begin
                    if (!r_out_valid) begin
                        r_out_data  <= w_sample;
                        r_out_last  <= (r_idx == 4'd15);
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (r_idx == 4'd15) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_idx       <= 4'd0;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_out_data <= w_sample;
                            r_out_last <= (r_idx == 4'd14);
                        end
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_ifft16_seq.sv
// Directed bench for ifft16_seq: table of single-bin / all-bin frames with
// hand-computed time-domain results, plus framing, backpressure and reset
// sequences.
module tb_ifft16_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [39:0] in_data = 40'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ifft16_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        int              bin;    // -1 means every bin carries the value
        int              re;
        int              im;
        int              tol;    // tolerance for samples 1..15
        int              tol0;   // tolerance for sample 0
        logic [15:0][15:0] exp_re;
        logic [15:0][15:0] exp_im;
    } vec_t;

    vec_t vecs[5];
    int c1k[16] = '{1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383, 0, 383, 707, 924};
    int s1k[16] = '{0, 383, 707, 924, 1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383};

    task automatic chk(input string name, input int act, input int exp, input int tol);
        checks++;
        if ((act > exp + tol) || (act < exp - tol)) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Send nbeats bins of vector vi; in_last is raised on beat last_at.
    task automatic send_frame(input int vi, input int nbeats, input int last_at, output int t_acc);
        t_acc = cyc;
        for (int k = 0; k < nbeats; k++) begin
            int re;
            int im;
            int guard;
            logic [19:0] r20;
            logic [19:0] i20;
            re = ((vecs[vi].bin == k) || (vecs[vi].bin == -1)) ? vecs[vi].re : 0;
            im = ((vecs[vi].bin == k) || (vecs[vi].bin == -1)) ? vecs[vi].im : 0;
            r20 = re[19:0];
            i20 = im[19:0];
            in_data  = {i20, r20};
            in_last  = (k == last_at);
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("in_ready_wait", int'(in_ready), 1, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            t_acc = cyc;
            chk($sformatf("err_beat%0d", k), int'(err), int'((k == last_at) != (k == 15)), 0);
        end
    endtask

    // Collect 16 samples of vector vi; optionally stall 5 cycles on sample stall_at.
    task automatic recv_frame(input int vi, input int t_acc, input int stall_at);
        int guard;
        int tol;
        logic [31:0] held;
        guard = 0;
        while (!out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("latency", cyc - t_acc, 33, 0);
        for (int n = 0; n < 16; n++) begin
            guard = 0;
            while (!out_valid && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            chk($sformatf("valid[%0d]", n), int'(out_valid), 1, 0);
            if (n == stall_at) begin
                held = out_data;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk("stall_hold", int'(out_valid && (out_data == held)), 1, 0);
                    chk("stall_in_ready", int'(in_ready), 0, 0);
                end
                out_ready = 1'b1;
            end
            tol = (n == 0) ? vecs[vi].tol0 : vecs[vi].tol;
            chk($sformatf("v%0d_re[%0d]", vi, n), int'($signed(out_data[15:0])),
                int'($signed(vecs[vi].exp_re[n])), tol);
            chk($sformatf("v%0d_im[%0d]", vi, n), int'($signed(out_data[31:16])),
                int'($signed(vecs[vi].exp_im[n])), tol);
            chk($sformatf("last[%0d]", n), int'(out_last), int'(n == 15), 0);
            chk("unload_in_ready", int'(in_ready), 0, 0);
            @(posedge clk); #1;
        end
        chk("done_out_valid", int'(out_valid), 0, 0);
        chk("done_in_ready", int'(in_ready), 1, 0);
        chk("done_busy", int'(busy), 0, 0);
    endtask

    initial begin
        int t;
        int seen;
        // Vector table: inputs plus hand-computed expected samples.
        vecs[0] = '{bin: 0, re: 16000, im: 0, tol: 0, tol0: 0, exp_re: '0, exp_im: '0};
        vecs[1] = '{bin: 1, re: 16000, im: 0, tol: 2, tol0: 0, exp_re: '0, exp_im: '0};
        vecs[2] = '{bin: -1, re: 524287, im: 0, tol: 2, tol0: 0, exp_re: '0, exp_im: '0};
        vecs[3] = '{bin: 4, re: 0, im: 16000, tol: 2, tol0: 2, exp_re: '0, exp_im: '0};
        vecs[4] = '{bin: 15, re: 16000, im: 0, tol: 2, tol0: 2, exp_re: '0, exp_im: '0};
        for (int n = 0; n < 16; n++) begin
            vecs[0].exp_re[n] = 16'(1000);
            vecs[0].exp_im[n] = 16'(0);
            vecs[1].exp_re[n] = 16'(c1k[n]);
            vecs[1].exp_im[n] = 16'(s1k[n]);
            vecs[2].exp_re[n] = (n == 0) ? 16'(32767) : 16'(0);
            vecs[2].exp_im[n] = 16'(0);
            vecs[3].exp_re[n] = 16'(-s1k[(4 * n) % 16]);
            vecs[3].exp_im[n] = 16'(c1k[(4 * n) % 16]);
            vecs[4].exp_re[n] = 16'(c1k[n]);
            vecs[4].exp_im[n] = 16'(-s1k[n]);
        end

        // Reset held 3 cycles with in_valid high.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 40'h0_0000_03E80;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_in_ready", int'(in_ready), 0, 0);
            chk("rst_out_valid", int'(out_valid), 0, 0);
            chk("rst_busy", int'(busy), 0, 0);
            chk("rst_err", int'(err), 0, 0);
            chk("rst_out_data", int'(out_data), 0, 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", int'(in_ready), 1, 0);
        chk("busy_after_rst", int'(busy), 0, 0);

        // Table-driven frames; the tone frame also gets a stall on sample 3.
        for (int vi = 0; vi < 5; vi++) begin
            send_frame(vi, 16, 15, t);
            chk("busy_compute", int'(busy), 1, 0);
            recv_frame(vi, t, (vi == 1) ? 3 : -1);
        end

        // Bin 15 without in_last: err pulses but the frame is still processed.
        send_frame(0, 16, -1, t);
        recv_frame(0, t, -1);

        // Early in_last on beat 9: err pulse, frame discarded, stay in LOAD.
        send_frame(1, 10, 9, t);
        @(posedge clk); #1;
        chk("err_pulse_end", int'(err), 0, 0);
        chk("early_last_in_ready", int'(in_ready), 1, 0);
        chk("early_last_busy", int'(busy), 0, 0);
        send_frame(1, 16, 15, t);
        recv_frame(1, t, -1);

        // Reset in the middle of COMPUTE: no output, back in LOAD.
        send_frame(2, 16, 15, t);
        repeat (10) begin @(posedge clk); #1; end
        chk("mid_compute_busy", int'(busy), 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_out_valid", int'(out_valid), 0, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0, 0);
        chk("midrst_in_ready", int'(in_ready), 1, 0);
        send_frame(0, 16, 15, t);
        recv_frame(0, t, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
